uart_rx_fifo: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver. Data width, parity mode and stop-bit count are configurable. Each bit is decided by a 3-sample majority vote, and received frames go into a small FIFO with per-word parity and framing error flags. A valid/ready handshake connects it to the core-side consumer, such as the loader or MMIO input port.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo_buf.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: FSM states, parity modes and FIFO entry layout.
package uart_pkg;

  localparam int RX_MAX_DATA_BITS = 8;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  typedef struct packed {
    logic                        perr;
    logic                        ferr;
    logic [RX_MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// First-word fall-through FIFO with push/pop handshake; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module uart_rx_fifo_buf #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is forced to zero while empty so the unreset storage never shows through.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; only pointers and count need a defined state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with 3-sample majority voting and an FWFT receive FIFO.
// Define UART_RX_BREAK_DET_EN to report all-zero frames as a brk pulse instead of data.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int DATA_BITS        = 8,
  parameter int PARITY_MODE      = PARITY_NONE,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rperr,
  output logic                 rferr,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic                 brk
);

  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int CW       = $clog2(BIT_CLKS);

  localparam logic [CW-1:0] CNT_S0   = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] CNT_DEC  = CW'(CLK_PER_HALF_BIT + 1);
  localparam logic [CW-1:0] CNT_WRAP = CW'(BIT_CLKS - 1);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync;
  logic rs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rxd};
  end
  assign rs = sync[1];

  rx_state_t                   state;
  logic [CW-1:0]               cnt;
  logic                        s0, s1;
  logic [2:0]                  bit_idx;
  logic                        stop_idx;
  logic [RX_MAX_DATA_BITS-1:0] shreg;
  logic                        perr, ferr;
  logic                        push_q;
  rx_entry_t                   entry_q;

  logic bit_val, decide, wrap, last_stop, frame_ferr;

  assign bit_val    = (s0 & s1) | (s0 & rs) | (s1 & rs);
  assign decide     = (cnt == CNT_DEC);
  assign wrap       = (cnt == CNT_WRAP);
  assign last_stop  = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_ferr = ferr | ~bit_val;

`ifdef UART_RX_BREAK_DET_EN
  logic par_bit, stop0, brk_q, is_brk;
  // The first stop bit is either the one being decided now or the one recorded earlier.
  assign is_brk = (shreg == '0) && ((PARITY_MODE == PARITY_NONE) || !par_bit)
                  && !((stop_idx == 1'b0) ? bit_val : stop0);
  assign brk = brk_q;
`else
  assign brk = 1'b0;
`endif

  // NOTE: every register below is updated with <= so all branches see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      push_q   <= 1'b0;
      entry_q  <= '0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit  <= 1'b0;
      stop0    <= 1'b1;
      brk_q    <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_q  <= 1'b0;
`endif
      if (state != IDLE && state != BREAK) begin
        cnt <= wrap ? '0 : cnt + CW'(1);
        if (cnt == CNT_S0) s0 <= rs;
        if (cnt == CNT_S1) s1 <= rs;
      end

      unique case (state)
        IDLE: begin
          if (!rs) begin
            state    <= START;
            cnt      <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
          end
        end
        START: begin
          if (decide && bit_val) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (decide) shreg[bit_idx] <= bit_val;
          if (wrap) begin
            if (bit_idx == 3'(DATA_BITS - 1))
              state <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: begin
          if (decide) begin
            perr <= ((^shreg) ^ bit_val) != (PARITY_MODE == PARITY_ODD);
`ifdef UART_RX_BREAK_DET_EN
            par_bit <= bit_val;
`endif
          end
          if (wrap) state <= STOP;
        end
        STOP: begin
          if (decide) begin
`ifdef UART_RX_BREAK_DET_EN
            if (stop_idx == 1'b0) stop0 <= bit_val;
`endif
            if (last_stop) begin
              // Commit at the decision point so the next start edge is never missed.
              cnt     <= '0;
              state   <= IDLE;
              entry_q <= '{perr: perr, ferr: frame_ferr, data: shreg};
`ifdef UART_RX_BREAK_DET_EN
              if (is_brk) begin
                brk_q <= 1'b1;
                state <= BREAK;
              end else begin
                push_q <= 1'b1;
              end
`else
              push_q  <= 1'b1;
`endif
            end else begin
              ferr <= frame_ferr;
            end
          end else if (wrap) begin
            stop_idx <= 1'b1;
          end
        end
        BREAK: begin
          if (rs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rx_entry_t head;
  logic      fifo_full, fifo_empty, pop;

  assign rvalid = ~fifo_empty;
  assign pop    = rready & rvalid;

  uart_rx_fifo_buf #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (entry_q),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rdata = head.data[DATA_BITS-1:0];
  assign rperr = head.perr;
  assign rferr = head.ferr;

  // A new drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     overrun <= 1'b0;
    else if (push_q && fifo_full && !pop)        overrun <= 1'b1;
    else if (ovr_clr)                            overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an even-parity instance,
// both at 16 clocks per bit.
module tb_uart_rx_fifo;

  localparam int H   = 8;
  localparam int BIT = 2 * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_a = 1'b1, rxd_b = 1'b1;
  logic rready_a = 1'b0, rready_b = 1'b0;
  logic ovr_clr_a = 1'b0, ovr_clr_b = 1'b0;

  logic [7:0] rdata_a, rdata_b;
  logic rperr_a, rferr_a, rvalid_a, overrun_a, brk_a;
  logic rperr_b, rferr_b, rvalid_b, overrun_b, brk_b;

  uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY_MODE(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rdata(rdata_a), .rperr(rperr_a),
    .rferr(rferr_a), .rvalid(rvalid_a), .rready(rready_a), .overrun(overrun_a),
    .ovr_clr(ovr_clr_a), .brk(brk_a));

  uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY_MODE(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rdata(rdata_b), .rperr(rperr_b),
    .rferr(rferr_b), .rvalid(rvalid_b), .rready(rready_b), .overrun(overrun_b),
    .ovr_clr(ovr_clr_b), .brk(brk_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int brk_cnt = 0;
  logic rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rvalid_a && !rv_prev && rise_cyc < 0) rise_cyc = cyc;
    rv_prev = rvalid_a;
    if (brk_a) brk_cnt = brk_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bits go out LSB first, one per BIT clocks; a set spike bit flips offsets 3 and 8 for one cycle.
  task automatic send(input bit sel, input logic [15:0] bits, input int n, input logic [15:0] spikes);
    logic v;
    for (int b = 0; b < n; b++)
      for (int o = 0; o < BIT; o++) begin
        @(negedge clk);
        if (b == 0 && o == 0) start_cyc = cyc;
        v = bits[b] ^ (spikes[b] & ((o == 3) || (o == 8)));
        if (sel) rxd_b = v; else rxd_a = v;
      end
    @(negedge clk);
    if (sel) rxd_b = 1'b1; else rxd_a = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop, input logic [15:0] spikes);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    f[9] = stop;
    send(1'b0, f, 10, spikes);
  endtask

  task automatic send_b(input logic [7:0] d, input logic par);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    f[9] = par;
    send(1'b1, f, 11, 16'h0000);
  endtask

  task automatic pop(input bit sel);
    @(negedge clk);
    if (sel) rready_b = 1'b1; else rready_a = 1'b1;
    @(negedge clk);
    rready_a = 1'b0;
    rready_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_rdata",   16'(rdata_a),   16'h0);
    check("rst_rperr",   16'(rperr_a),   16'h0);
    check("rst_rferr",   16'(rferr_a),   16'h0);
    check("rst_rvalid",  16'(rvalid_a),  16'h0);
    check("rst_overrun", 16'(overrun_a), 16'h0);
    check("rst_brk",     16'(brk_a),     16'h0);
    check("rst_rvalid_b", 16'(rvalid_b), 16'h0);
    check("rst_brk_b",   16'(brk_b),     16'h0);

    // Start seen 3 clocks after the drop, last stop decided at 3+9*16+9, rvalid 2 clocks later.
    rise_cyc = -1;
    send_a(8'h55, 1'b1, 16'h0000);
    check("lat_55",   16'(rise_cyc - start_cyc), 16'd158);
    check("data_55",  16'(rdata_a), 16'h55);
    check("perr_55",  16'(rperr_a), 16'h0);
    check("ferr_55",  16'(rferr_a), 16'h0);
    pop(1'b0);
    check("empty_55", 16'(rvalid_a), 16'h0);

    send_a(8'h0F, 1'b0, 16'h0000);
    check("data_0f",  16'(rdata_a),  16'h0F);
    check("ferr_0f",  16'(rferr_a),  16'h1);
    pop(1'b0);
    check("empty_0f", 16'(rvalid_a), 16'h0);
    send_a(8'h3C, 1'b1, 16'h0000);
    check("data_3c",  16'(rdata_a),  16'h3C);
    check("ferr_3c",  16'(rferr_a),  16'h0);
    pop(1'b0);

    @(negedge clk);
    rxd_a = 1'b0;
    repeat (3) @(negedge clk);
    rxd_a = 1'b1;
    repeat (4 * BIT) @(negedge clk);
    check("glitch_rvalid", 16'(rvalid_a), 16'h0);

    send_a(8'hC6, 1'b1, 16'h01FE);
    check("data_c6", 16'(rdata_a), 16'hC6);
    check("ferr_c6", 16'(rferr_a), 16'h0);
    pop(1'b0);

    for (int i = 1; i <= 5; i++) begin
      send_a(8'(i), 1'b1, 16'h0000);
      if (i == 4) begin
        check("full_overrun", 16'(overrun_a), 16'h0);
        check("full_head",    16'(rdata_a),   16'h01);
      end
    end
    check("ovr_set",    16'(overrun_a), 16'h1);
    check("ovr_rvalid", 16'(rvalid_a),  16'h1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), 16'(rdata_a), 16'(i));
      pop(1'b0);
    end
    check("drain_empty", 16'(rvalid_a),  16'h0);
    check("ovr_sticky",  16'(overrun_a), 16'h1);
    pop(1'b0);
    check("pop_empty",   16'(rvalid_a),  16'h0);
    @(negedge clk);
    ovr_clr_a = 1'b1;
    @(negedge clk);
    ovr_clr_a = 1'b0;
    check("ovr_clr", 16'(overrun_a), 16'h0);

    // 0xA3 has four ones, so the even-parity bit is 0.
    send_b(8'hA3, 1'b0);
    check("par_a3_data", 16'(rdata_b), 16'hA3);
    check("par_a3_p0",   16'(rperr_b), 16'h0);
    check("par_a3_ferr", 16'(rferr_b), 16'h0);
    pop(1'b1);
    send_b(8'hA3, 1'b1);
    check("par_a3_p1",   16'(rperr_b), 16'h1);
    pop(1'b1);
    send_b(8'h07, 1'b1);
    check("par_07_p1",   16'(rperr_b), 16'h0);
    pop(1'b1);
    check("par_empty",   16'(rvalid_b),  16'h0);
    check("par_ovr",     16'(overrun_b), 16'h0);

    brk_cnt = 0;
    @(negedge clk);
    rxd_a = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    rxd_a = 1'b1;
    repeat (6 * BIT) @(negedge clk);
`ifdef UART_RX_BREAK_DET_EN
    check("brk_pulses", 16'(brk_cnt),  16'd1);
    check("brk_empty",  16'(rvalid_a), 16'h0);
`else
    check("brk_pulses", 16'(brk_cnt),  16'd0);
    check("brk_rvalid", 16'(rvalid_a), 16'h1);
    check("brk_data",   16'(rdata_a),  16'h00);
    check("brk_ferr",   16'(rferr_a),  16'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
